system_cpu_0_oci_trace_packer: RTL and testbench

//   Parametrised OCI trace-capture packer for the Nios II debug core. Packs

---
 rtl/system_cpu_0_oci_trace_packer.sv | 203 ++++++++++++++++++++
 tb/tb_system_cpu_0_oci_trace_packer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/system_cpu_0_oci_trace_packer.sv
// ---------------------------------------------------------------------------
// system_cpu_0_oci_trace_packer
//   OCI trace-capture packer for the Nios II debug core. Collects PACK_N
//   trace entries of ENTRY_W bits into one word and hands the word to the
//   trace sink over a valid/ready handshake. The live packing buffer is
//   exported for debug visibility. test_ending drains the partial word and
//   then raises the sticky test_has_ended.
//
//   Optional feature: define OCI_TRACE_OVF_CNT_EN to build the saturating
//   dropped-entry counter; otherwise ovf_count is tied to 0.
//
// Ports
//   clk, reset        rising-edge clock; async active-high reset (sync release)
//   tr_valid/tr_data  trace entry strobe and payload
//   flush             pulse: push out the partial word
//   test_ending       end-of-test request (level or pulse)
//   dct_buffer        live packing buffer, slot 0 in LSBs
//   dct_count         entries held in dct_buffer (0..PACK_N)
//   out_valid/out_data/out_count/out_ready   packed word handshake
//   test_has_ended    sticky, drain complete
//   ovf_count         dropped-entry count
// ---------------------------------------------------------------------------

// One packing slot: new entry wins over the clear so an entry accepted on a
// transfer edge lands in slot 0 of the freshly emptied buffer.
module system_cpu_0_oci_trace_packer_slot #(
    parameter int ENTRY_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               we,
    input  logic [ENTRY_W-1:0] d,
    output logic [ENTRY_W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= '0;
        else if (we)  q <= d;
        else if (clr) q <= '0;
    end
endmodule

module system_cpu_0_oci_trace_packer #(
    parameter int ENTRY_W = 10,
    parameter int PACK_N  = 3,
    parameter int CNT_W   = 4,
    parameter int OVF_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tr_valid,
    input  logic [ENTRY_W-1:0]        tr_data,
    input  logic                      flush,
    input  logic                      test_ending,
    output logic [ENTRY_W*PACK_N-1:0] dct_buffer,
    output logic [CNT_W-1:0]          dct_count,
    output logic                      out_valid,
    output logic [ENTRY_W*PACK_N-1:0] out_data,
    output logic [CNT_W-1:0]          out_count,
    input  logic                      out_ready,
    output logic                      test_has_ended,
    output logic [OVF_W-1:0]          ovf_count
);
    localparam int WORD_W = ENTRY_W * PACK_N;

    generate
        if (CNT_W < $clog2(PACK_N + 1)) begin : g_cnt_w_check
            $error("CNT_W is too narrow to count PACK_N entries");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Reset: asserts asynchronously, releases two clk edges after reset drops
    // so every flop leaves reset on the same edge.
    // -----------------------------------------------------------------------
    logic [1:0] rst_sync;
    logic       rst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_sync <= 2'b11;
        else       rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst = rst_sync[1];

    // -----------------------------------------------------------------------
    // Drain FSM
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ENDED} state_t;
    state_t state, state_nxt;
    logic   is_run;
    logic   flush_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (test_ending) state_nxt = ST_DRAIN;
            // Done only once nothing is buffered, nothing waits at the sink
            // and no flush is still owed.
            ST_DRAIN: if (dct_count == '0 && !out_valid && !flush_pend)
                          state_nxt = ST_ENDED;
            default:  state_nxt = ST_ENDED;
        endcase
    end

    always_comb begin
        is_run         = 1'b0;
        test_has_ended = 1'b0;
        case (state)
            ST_RUN:   is_run = 1'b1;
            ST_ENDED: test_has_ended = 1'b1;
            default:  ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Packing datapath
    // -----------------------------------------------------------------------
    logic                              out_free, full, xfer, accept;
    logic [CNT_W-1:0]                  base_cnt, cnt_nxt;
    logic [PACK_N-1:0]                 slot_we;
    logic [PACK_N-1:0][ENTRY_W-1:0]    slot_q;
    logic [PACK_N-1:0][ENTRY_W-1:0]    word_masked;
    logic                              flush_set, flush_pend_nxt;

    assign out_free = !out_valid || out_ready;
    assign full     = (dct_count == CNT_W'(PACK_N));
    assign xfer     = out_free && (full || (flush_pend && dct_count != '0));
    // A full buffer still takes an entry when it empties on the same edge.
    assign accept   = tr_valid && is_run && (!full || xfer);
    assign base_cnt = xfer ? '0 : dct_count;
    assign cnt_nxt  = base_cnt + CNT_W'(accept);

    for (genvar i = 0; i < PACK_N; i++) begin : g_slot
        assign slot_we[i]     = accept && (base_cnt == CNT_W'(i));
        assign word_masked[i] = (CNT_W'(i) < dct_count) ? slot_q[i] : '0;

        system_cpu_0_oci_trace_packer_slot #(
            .ENTRY_W (ENTRY_W)
        ) u_slot (
            .clk (clk),
            .rst (rst),
            .clr (xfer),
            .we  (slot_we[i]),
            .d   (tr_data),
            .q   (slot_q[i])
        );
    end

    assign dct_buffer = slot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dct_count <= '0;
        else     dct_count <= cnt_nxt;
    end

    // Flush request is remembered until the partial word leaves; it is
    // dropped whenever the buffer ends up empty so no empty word is emitted.
    assign flush_set      = is_run && (flush || test_ending);
    assign flush_pend_nxt = ((flush_pend && !xfer) || flush_set) && (cnt_nxt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flush_pend <= 1'b0;
        else     flush_pend <= flush_pend_nxt;
    end

    // -----------------------------------------------------------------------
    // Output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= WORD_W'(word_masked);
            out_count <= dct_count;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Dropped-entry counter
    // -----------------------------------------------------------------------
`ifdef OCI_TRACE_OVF_CNT_EN
    logic drop;
    assign drop = tr_valid && !accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            ovf_count <= '0;
        else if (drop && ovf_count != '1)   ovf_count <= ovf_count + 1'b1;
    end
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_system_cpu_0_oci_trace_packer.sv
module tb_system_cpu_0_oci_trace_packer;
    localparam int EW = 10;
    localparam int PN = 3;
    localparam int CW = 4;
    localparam int OW = 16;
    localparam int WW = EW * PN;
`ifdef OCI_TRACE_OVF_CNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tr_valid = 1'b0;
    logic [EW-1:0] tr_data = '0;
    logic          flush = 1'b0;
    logic          test_ending = 1'b0;
    logic          out_ready = 1'b0;
    logic [WW-1:0] dct_buffer, out_data;
    logic [CW-1:0] dct_count, out_count;
    logic          out_valid, test_has_ended;
    logic [OW-1:0] ovf_count;

    system_cpu_0_oci_trace_packer #(
        .ENTRY_W(EW), .PACK_N(PN), .CNT_W(CW), .OVF_W(OW)
    ) dut (
        .clk(clk), .reset(reset), .tr_valid(tr_valid), .tr_data(tr_data),
        .flush(flush), .test_ending(test_ending), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .out_valid(out_valid), .out_data(out_data),
        .out_count(out_count), .out_ready(out_ready),
        .test_has_ended(test_has_ended), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [WW-1:0] d; int c; } word_t;
    int            m_q[$];          // entries waiting in the packing buffer
    bit            m_ov = 0;
    logic [WW-1:0] m_od = '0;
    int            m_oc = 0;
    bit            m_pend = 0;
    int            m_st = 0;        // 0 run, 1 drain, 2 ended
    int            m_ovf = 0;
    int            rcnt = 2;        // edges still held in reset after release
    word_t         mlog[$];
    word_t         dlog[$];

    function automatic logic [WW-1:0] pack_q();
        logic [WW-1:0] w = '0;
        foreach (m_q[i]) w |= WW'(m_q[i]) << (i * EW);
        return w;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        int cnt;
        bit free, full, xfer, run, acc;
        if (reset) begin
            m_q.delete(); m_ov = 0; m_od = '0; m_oc = 0;
            m_pend = 0; m_st = 0; m_ovf = 0; rcnt = 2;
        end else if (rcnt > 0) begin
            rcnt--;
        end else begin
            cnt  = m_q.size();
            free = !m_ov || out_ready;
            full = (cnt == PN);
            xfer = free && (full || (m_pend && cnt > 0));
            run  = (m_st == 0);
            acc  = tr_valid && run && (!full || xfer);
            if (m_ov && out_ready) mlog.push_back('{m_od, m_oc});
            if (m_st == 0 && test_ending) m_st = 1;
            else if (m_st == 1 && cnt == 0 && !m_ov && !m_pend) m_st = 2;
            if (xfer) begin
                m_od = pack_q(); m_oc = cnt; m_ov = 1; m_q.delete();
            end else if (out_ready) m_ov = 0;
            if (acc) m_q.push_back(int'(tr_data));
            m_pend = (m_pend && !xfer) || (run && (flush || test_ending));
            if (m_q.size() == 0) m_pend = 0;
            if (tr_valid && !acc && OVF_EN && m_ovf != (1 << OW) - 1) m_ovf++;
        end
    end

    always @(posedge clk)
        if (out_valid && out_ready) dlog.push_back('{out_data, int'(out_count)});

    always @(negedge clk) begin
        chk("dct_count", dct_count, m_q.size());
        chk("dct_buffer", dct_buffer, pack_q());
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_data", out_data, m_od);
            chk("out_count", out_count, m_oc);
        end
        chk("test_has_ended", test_has_ended, m_st == 2);
        chk("ovf_count", ovf_count, m_ovf);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [WW-1:0] exp_w [7];
    int            exp_c [7];

    initial begin
        exp_w = '{30'h00300801, 30'h01304811, 30'h01605414, 30'h000557FF,
                  30'h000000AA, 30'h00300801, 30'h00601404};
        exp_c = '{3, 3, 3, 2, 1, 3, 3};

        step(2); reset = 0; step(4);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_dct_count", dct_count, 0);

        // 1: three entries pack into one word
        out_ready = 1; tr_valid = 1;
        tr_data = 10'h001; step(1);
        tr_data = 10'h002; step(1);
        tr_data = 10'h003; step(1);
        tr_valid = 0; step(1);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_data", out_data, 30'h00300801);
        chk("t1_out_count", out_count, 3);
        chk("t1_dct_count", dct_count, 0);
        step(1);
        chk("t1_out_valid_clr", out_valid, 0);

        // 2: backpressure, seventh entry dropped
        out_ready = 0; tr_valid = 1;
        for (int i = 0; i < 7; i++) begin
            tr_data = EW'(10'h011 + i); step(1);
        end
        tr_valid = 0;
        chk("t2_dct_count", dct_count, 3);
        chk("t2_out_data", out_data, 30'h01304811);
        chk("t2_dct_buffer", dct_buffer, 30'h01605414);
        chk("t2_ovf", ovf_count, OVF_EN ? 1 : 0);
        out_ready = 1; step(1);
        chk("t2_word2", out_data, 30'h01605414);
        chk("t2_dct_count0", dct_count, 0);
        step(1);
        chk("t2_out_valid_clr", out_valid, 0);

        // 3: flush partial word, then flush with empty buffer
        tr_valid = 1; tr_data = 10'h3FF; step(1);
        tr_data = 10'h155; step(1);
        tr_valid = 0; flush = 1; step(1);
        flush = 0; step(1);
        chk("t3_out_data", out_data, 30'h000557FF);
        chk("t3_out_count", out_count, 2);
        step(1);
        flush = 1; step(1);
        flush = 0; step(2);
        chk("t3_empty_flush", out_valid, 0);

        // 4: end-of-test drain
        tr_valid = 1; tr_data = 10'h0AA; step(1);
        tr_valid = 0; test_ending = 1; step(2);
        chk("t4_out_data", out_data, 30'h000000AA);
        chk("t4_out_count", out_count, 1);
        chk("t4_not_ended", test_has_ended, 0);
        step(1);
        chk("t4_not_ended_hs", test_has_ended, 0);
        step(1);
        chk("t4_ended", test_has_ended, 1);
        tr_valid = 1; tr_data = 10'h123; step(2);
        tr_valid = 0;
        chk("t4_ignored", dct_count, 0);
        chk("t4_ovf", ovf_count, OVF_EN ? 3 : 0);

        // 5: async reset, first while ended, then with data in flight
        #1 reset = 1; #1;
        chk("t5_ended_async", test_has_ended, 0);
        step(1); test_ending = 0; reset = 0; step(4);
        out_ready = 0; tr_valid = 1;
        for (int i = 0; i < 5; i++) begin
            tr_data = EW'(10'h021 + i); step(1);
        end
        tr_valid = 0;
        chk("t5_pre_valid", out_valid, 1);
        chk("t5_pre_count", dct_count, 2);
        #1 reset = 1; #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_dct_count", dct_count, 0);
        chk("t5_dct_buffer", dct_buffer, 0);
        step(1); reset = 0; step(4);

        // 6: transfer and accept on the same edge
        out_ready = 0; tr_valid = 1;
        for (int i = 1; i <= 6; i++) begin
            tr_data = EW'(i); step(1);
        end
        chk("t6_full", dct_count, 3);
        out_ready = 1; tr_data = 10'h007; step(1);
        tr_valid = 0;
        chk("t6_dct_count", dct_count, 1);
        chk("t6_dct_buffer", dct_buffer, 30'h7);
        chk("t6_out_data", out_data, 30'h00601404);
        chk("t6_ovf", ovf_count, 0);
        step(2);

        // delivered words: model pinned by literals, DUT against model
        chk("model_log_len", mlog.size(), 7);
        chk("dut_log_len", dlog.size(), mlog.size());
        for (int i = 0; i < 7; i++) begin
            if (i < mlog.size()) begin
                chk("model_word", mlog[i].d, exp_w[i]);
                chk("model_cnt", mlog[i].c, exp_c[i]);
                if (i < dlog.size()) begin
                    chk("dut_word", dlog[i].d, mlog[i].d);
                    chk("dut_cnt", dlog[i].c, mlog[i].c);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
